// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and defaults for the load/store unit.
//   SZ_BYTE/SZ_HALF/SZ_WORD : req_size encodings (2'b11 is illegal)
//   LSU_MEM_WORDS           : default number of implemented DataMemory words
//   lsu_state_t             : MEM-stage controller states
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int LSU_MEM_WORDS = 8192;
    typedef enum logic [1:0] {S_IDLE, S_LD_WAIT, S_RMW_WAIT, S_RMW_WR} lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: big-endian byte/half lane handling, purely combinational.
//   i_word, i_off, i_size, i_signed -> o_load   : extracted, zero/sign-extended load result
//   i_old, i_new, i_off, i_size     -> o_merged : i_new's low byte/half inserted into i_old
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [1:0]        i_off,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_old,
    input  logic [DATA_W-1:0] i_new,
    output logic [DATA_W-1:0] o_load,
    output logic [DATA_W-1:0] o_merged
);
    logic [4:0]        w_lsh;
    logic [4:0]        w_byte_rsh;
    logic [4:0]        w_half_rsh;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_ins;

    // Offset 0 is the most significant lane, so loads shift right by (3-off)
    // bytes and stores shift the top-aligned lane right by off bytes.
    assign w_lsh      = {i_off, 3'b000};
    assign w_byte_rsh = {~i_off, 3'b000};
    assign w_half_rsh = {~i_off[1], 4'b0000};
    assign w_byte     = 8'(i_word >> w_byte_rsh);
    assign w_half     = 16'(i_word >> w_half_rsh);

    always_comb begin
        o_load = (i_size == SZ_BYTE) ? {{(DATA_W-8){i_signed & w_byte[7]}}, w_byte} :
                 (i_size == SZ_HALF) ? {{(DATA_W-16){i_signed & w_half[15]}}, w_half} : i_word;
        w_mask = ((i_size == SZ_BYTE) ? {8'hFF, {(DATA_W-8){1'b0}}} :
                                        {16'hFFFF, {(DATA_W-16){1'b0}}}) >> w_lsh;
        w_ins  = ((i_size == SZ_BYTE) ? {i_new[7:0], {(DATA_W-8){1'b0}}} :
                                        {i_new[15:0], {(DATA_W-16){1'b0}}}) >> w_lsh;
        o_merged = (i_size == SZ_WORD) ? i_new : ((i_old & ~w_mask) | w_ins);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage controller in front of a word-addressed DataMemory
// with a 1-cycle registered read.
//   req_*               : pipeline request (byte address, store data, load/store, size, signed)
//   stall / addr_err    : combinational pipeline hold and 1-cycle error flag
//   load_valid/load_data: registered load result pulse
//   MemRead/MemWrite/Address/WriteData/ReadData : DataMemory interface
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = LSU_MEM_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              addr_err,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData
);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic [ADDR_W-1:0] w_word_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [15:0]       r_wdata;
    logic [DATA_W-1:0] r_merged;
    logic [DATA_W-1:0] r_load_data;
    logic              r_load_valid;
    logic [DATA_W-1:0] w_load_ext;
    logic [DATA_W-1:0] w_merged;
    logic              w_idle;
    logic              w_req;
    logic              w_err;
    logic              w_go;
    logic              w_ld;
    logic              w_sw;
    logic              w_sub;

    assign w_word_addr = req_addr[ADDR_W+1:2];
    assign w_idle      = (r_state == S_IDLE);
    // A request with neither load nor store is a bubble and never errors.
    assign w_req       = w_idle & req_valid & (req_load | req_store);
    assign w_err       = (req_load & req_store) | (req_size == 2'b11) |
                         ((req_size == SZ_HALF) & req_addr[0]) |
                         ((req_size == SZ_WORD) & (|req_addr[1:0])) |
                         (|req_addr[31:ADDR_W+2]) | ({1'b0, w_word_addr} >= LIMIT);
    assign w_go        = w_req & ~w_err;
    assign w_ld        = w_go & req_load;
    assign w_sw        = w_go & req_store & (req_size == SZ_WORD);
    assign w_sub       = w_go & req_store & (req_size != SZ_WORD);
    assign load_valid  = r_load_valid;
    assign load_data   = r_load_data;

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_word   (ReadData),
        .i_off    (r_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_old    (ReadData),
        .i_new    ({{(DATA_W-16){1'b0}}, r_wdata}),
        .o_load   (w_load_ext),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = w_ld ? S_LD_WAIT : w_sub ? S_RMW_WAIT : S_IDLE;
            S_RMW_WAIT: w_next = S_RMW_WR;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        addr_err  = w_req & w_err;
        MemRead   = w_ld | w_sub;
        MemWrite  = w_sw | (r_state == S_RMW_WR);
        Address   = (r_state == S_RMW_WR) ? r_addr : w_word_addr;
        WriteData = (r_state == S_RMW_WR) ? r_merged : req_wdata;
        stall     = w_ld | w_sub | ~w_idle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_wdata      <= '0;
            r_merged     <= '0;
            r_load_valid <= 1'b0;
            r_load_data  <= '0;
        end else begin
            r_load_valid <= (r_state == S_LD_WAIT);
            if (w_go) begin
                r_addr   <= w_word_addr;
                r_off    <= req_addr[1:0];
                r_size   <= req_size;
                r_signed <= req_signed;
                r_wdata  <= req_wdata[15:0];
            end
            if (r_state == S_LD_WAIT) r_load_data <= w_load_ext;
            if (r_state == S_RMW_WAIT) r_merged <= w_merged;
        end
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage controller between the pipeline (ALU address, rt store data, load/store control) and the word-addressed DataMemory, which has a 1-cycle registered read.
- Converts MIPS byte addresses to word addresses and extracts LB/LBU/LH/LHU/LW results.
- Implements SB/SH as read-modify-write.
- Flags misaligned or out-of-range accesses and stalls the pipeline while multi-cycle operations are in flight.

Parameters:
- ADDR_W, 16, word-address width driven to DataMemory
- DATA_W, 32, word width
- MEM_WORDS, 8192, number of implemented words; word address >= MEM_WORDS is out of range

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  MEM-stage request present this cycle
- req_load  in  1  load request
- req_store  in  1  store request
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend sub-word loads (LB/LH)
- req_addr  in  32  byte address from ALU
- req_wdata  in  32  store data, right-justified
- stall  out  1  hold the pipeline (combinational)
- addr_err  out  1  misaligned, out-of-range or illegal request (combinational, 1 cycle)
- load_valid  out  1  registered pulse: load_data is valid
- load_data  out  32  registered extracted load result
- MemRead  out  1  to DataMemory
- MemWrite  out  1  to DataMemory
- Address  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
- WriteData  out  32  to DataMemory
- ReadData  in  32  from DataMemory; valid the cycle after MemRead

Behaviour:
- Clocking and reset: one clock `clk`. Synchronous active-high `reset` clears state to IDLE, load_valid to 0, load_data to 0, and the latched request registers to 0.
- Outputs in IDLE with no request: MemRead, MemWrite and stall are 0.
- Reset mid-operation: the operation is abandoned. No pending RMW write is issued, and no load_valid is produced.
- Byte order: big-endian. Byte offset 0 maps to bits [31:24]. Half offset 0 maps to [31:16].
- Error check, IDLE only: addr_err=1 and no memory access when any of the following holds. No state change and no stall.
  - req_load and req_store both set
  - req_size=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - req_addr[31:ADDR_W+2]!=0
  - word address >= MEM_WORDS
- req_valid with neither load nor store: ignored.
- States: IDLE, LD_WAIT, RMW_WAIT, RMW_WR.
- Word store (IDLE, valid): MemWrite=1, WriteData=req_wdata, Address driven, stall=0. Single cycle; stays in IDLE.
- Load, cycle 0 (IDLE): MemRead=1, stall=1. Latch size, signed and byte offset. Go to LD_WAIT.
- Load, cycle 1 (LD_WAIT): stall=1. Extract from ReadData (zero- or sign-extend) into load_data. Go to IDLE.
- Load, cycle 2: load_valid=1 for exactly one cycle. stall=0, so a new request may be accepted in this same cycle.
- Sub-word store, cycle 0 (IDLE): MemRead=1, stall=1. Latch Address, offset, size and the low byte/half of req_wdata. Go to RMW_WAIT.
- Sub-word store, cycle 1 (RMW_WAIT): merge the latched byte/half into ReadData at the offset and register the result. Go to RMW_WR. stall=1.
- Sub-word store, cycle 2 (RMW_WR): MemWrite=1, WriteData=merged word, Address=latched address, stall=1. Go to IDLE.
- Sub-word store, cycle 3: next request accepted.
- Request inputs are ignored outside IDLE (the pipeline is stalled). MemRead and MemWrite are never both 1.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - the LSU_MEM_WORDS default constant
- One combinational sub-module, lsu_lane_align:
  - load-extract path: word, offset, size, signed -> result
  - store-merge path: old word, new data, offset, size -> merged word
- The FSM, error check and stall logic stay in load_store_unit.

Test Plan:
1. Word store then load:
   - SW 0xDEADBEEF at byte 0x10 -> MemWrite=1, Address=4, no stall.
   - LW 0x10 -> stall for 2 cycles, then load_valid pulse with load_data=0xDEADBEEF.
2. Sub-word loads with memory word 0x80FF7F01 at byte 0x20:
   - LB 0x20 -> 0xFFFFFF80
   - LBU 0x20 -> 0x00000080
   - LH 0x22 -> 0x00007F01
   - LH 0x20 -> 0xFFFF80FF
3. RMW store:
   - SB 0xAA at byte 0x21 on word 0x11223344 -> 3-cycle stall, single MemWrite with WriteData=0x11AA3344.
   - SH 0xBEEF at byte 0x22 on the same original word -> WriteData=0x1122BEEF.
4. Errors, each -> addr_err for 1 cycle, MemRead=MemWrite=0, stall=0:
   - LW 0x13
   - LH 0x15
   - LW 0x00008000 (word 8192)
   - req_size=11
   - load+store together
5. Reset asserted during RMW_WAIT -> no MemWrite afterwards, state IDLE, load_valid=0, load_data=0.
6. Back-to-back LW, LW, SW:
   - Each LW is accepted on the cycle its predecessor's load_valid pulses.
   - The SW completes with no stall.
   - Memory order is preserved.
